// File: rtl/dispatch_stage.sv
// Dispatch stage: renames one decoded instruction per cycle, resolves operands from
// regfile/ROB/CDB, holds it while snooping the CDBs, and issues it to a reservation station.
module dispatch_stage #(
    parameter int ROB_SIZE = 32,
    parameter int NUM_RS   = 4,
    parameter int NUM_CDB  = 2,
    parameter int CMD_W    = 10,
    localparam int TAG_W   = $clog2(ROB_SIZE + 1),
    localparam int SEL_W   = $clog2(NUM_RS)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              flush_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [4:0]                        in_rd_i,
    input  logic [4:0]                        in_rn_i,
    input  logic [4:0]                        in_rm_i,
    input  logic                              in_regwrite_i,
    input  logic                              in_use_imm_i,
    input  logic [63:0]                       in_imm_i,
    input  logic [SEL_W-1:0]                  in_rs_sel_i,
    input  logic [CMD_W-1:0]                  in_cmd_i,
    output logic [4:0]                        map_rd_addr1_o,
    output logic [4:0]                        map_rd_addr2_o,
    input  logic [TAG_W-1:0]                  map_rd_data1_i,
    input  logic [TAG_W-1:0]                  map_rd_data2_i,
    output logic                              map_we_o,
    output logic [4:0]                        map_wr_addr_o,
    output logic [TAG_W-1:0]                  map_wr_data_o,
    input  logic [63:0]                       rf_rd_data1_i,
    input  logic [63:0]                       rf_rd_data2_i,
    output logic [TAG_W-1:0]                  rob_rd_addr1_o,
    output logic [TAG_W-1:0]                  rob_rd_addr2_o,
    input  logic [64:0]                       rob_rd_data1_i,
    input  logic [64:0]                       rob_rd_data2_i,
    input  logic [TAG_W-1:0]                  rob_tail_i,
    input  logic                              rob_full_i,
    output logic                              rob_alloc_o,
    output logic [4:0]                        rob_alloc_data_o,
    input  logic [NUM_CDB-1:0]                cdb_valid_i,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag_i,
    input  logic [NUM_CDB-1:0][63:0]          cdb_val_i,
    output logic [NUM_RS-1:0]                 rs_valid_o,
    input  logic [NUM_RS-1:0]                 rs_ready_i,
    output logic [TAG_W-1:0]                  rs_dest_tag_o,
    output logic [TAG_W-1:0]                  rs_tag1_o,
    output logic [TAG_W-1:0]                  rs_tag2_o,
    output logic [63:0]                       rs_val1_o,
    output logic [63:0]                       rs_val2_o,
    output logic [CMD_W-1:0]                  rs_cmd_o
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      val;
    } opnd_t;

    // Replace a pending tag with a matching CDB value; the lowest-index port wins.
    function automatic opnd_t cdb_snoop(input opnd_t o,
                                        input logic [NUM_CDB-1:0] v,
                                        input logic [NUM_CDB-1:0][TAG_W-1:0] t,
                                        input logic [NUM_CDB-1:0][63:0] d);
        opnd_t r;
        r = o;
        if (o.tag != '0) begin
            for (int i = NUM_CDB - 1; i >= 0; i--) begin
                if (v[i] && (t[i] == o.tag)) begin
                    r.tag = '0;
                    r.val = d[i];
                end
            end
        end
        return r;
    endfunction

    function automatic opnd_t resolve(input logic [TAG_W-1:0] map_tag,
                                      input logic [63:0] rf_val,
                                      input logic [64:0] rob_val,
                                      input logic [NUM_CDB-1:0] v,
                                      input logic [NUM_CDB-1:0][TAG_W-1:0] t,
                                      input logic [NUM_CDB-1:0][63:0] d);
        opnd_t r;
        if (map_tag == '0) begin
            r.tag = '0;
            r.val = rf_val;
        end else begin
            r = cdb_snoop('{tag: map_tag, val: 64'd0}, v, t, d);
            if (r.tag != '0 && rob_val[64]) begin
                r.tag = '0;
                r.val = rob_val[63:0];
            end
        end
        return r;
    endfunction

    logic              d_valid_q, d_valid_d;
    logic [SEL_W-1:0]  d_sel_q, d_sel_d;
    logic [TAG_W-1:0]  d_dest_q, d_dest_d;
    opnd_t             d_op1_q, d_op1_d, d_op2_q, d_op2_d;
    logic [CMD_W-1:0]  d_cmd_q, d_cmd_d;

    logic  fire, accept;
    opnd_t op1_new, op2_new, op1_held, op2_held;

    always_comb begin
        // Flush squashes the held instruction before it can fire.
        fire       = d_valid_q & ~flush_i & rs_ready_i[d_sel_q];
        in_ready_o = ~rob_full_i & ~flush_i & (~d_valid_q | fire);
        accept     = in_valid_i & in_ready_o;

        op1_new = resolve(map_rd_data1_i, rf_rd_data1_i, rob_rd_data1_i,
                          cdb_valid_i, cdb_tag_i, cdb_val_i);
        if (in_use_imm_i) begin
            op2_new.tag = '0;
            op2_new.val = in_imm_i;
        end else begin
            op2_new = resolve(map_rd_data2_i, rf_rd_data2_i, rob_rd_data2_i,
                              cdb_valid_i, cdb_tag_i, cdb_val_i);
        end
        op1_held = cdb_snoop(d_op1_q, cdb_valid_i, cdb_tag_i, cdb_val_i);
        op2_held = cdb_snoop(d_op2_q, cdb_valid_i, cdb_tag_i, cdb_val_i);

        d_valid_d = d_valid_q;
        d_sel_d   = d_sel_q;
        d_dest_d  = d_dest_q;
        d_op1_d   = op1_held;
        d_op2_d   = op2_held;
        d_cmd_d   = d_cmd_q;
        if (flush_i) begin
            d_valid_d = 1'b0;
        end else if (accept) begin
            d_valid_d = 1'b1;
            d_sel_d   = in_rs_sel_i;
            d_dest_d  = rob_tail_i;
            d_op1_d   = op1_new;
            d_op2_d   = op2_new;
            d_cmd_d   = in_cmd_i;
        end else if (fire) begin
            d_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            d_valid_q <= 1'b0;
            d_sel_q   <= '0;
            d_dest_q  <= '0;
            d_op1_q   <= '0;
            d_op2_q   <= '0;
            d_cmd_q   <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            d_sel_q   <= d_sel_d;
            d_dest_q  <= d_dest_d;
            d_op1_q   <= d_op1_d;
            d_op2_q   <= d_op2_d;
            d_cmd_q   <= d_cmd_d;
        end
    end

    assign map_rd_addr1_o   = in_rn_i;
    assign map_rd_addr2_o   = in_rm_i;
    assign map_we_o         = accept & in_regwrite_i & (in_rd_i != 5'd31);
    assign map_wr_addr_o    = in_rd_i;
    assign map_wr_data_o    = rob_tail_i;
    assign rob_rd_addr1_o   = map_rd_data1_i;
    assign rob_rd_addr2_o   = map_rd_data2_i;
    assign rob_alloc_o      = accept;
    assign rob_alloc_data_o = accept ? in_rd_i : 5'd0;

    always_comb begin
        for (int k = 0; k < NUM_RS; k++) begin
            rs_valid_o[k] = d_valid_q & ~flush_i & (d_sel_q == SEL_W'(k));
        end
    end

    // Operands carry the same-cycle CDB merge so a wakeup in the fire cycle is kept.
    assign rs_dest_tag_o = d_valid_q ? d_dest_q     : '0;
    assign rs_tag1_o     = d_valid_q ? op1_held.tag : '0;
    assign rs_tag2_o     = d_valid_q ? op2_held.tag : '0;
    assign rs_val1_o     = d_valid_q ? op1_held.val : '0;
    assign rs_val2_o     = d_valid_q ? op2_held.val : '0;
    assign rs_cmd_o      = d_valid_q ? d_cmd_q      : '0;

endmodule
